// File: rtl/prog_loader_pkg.sv
// Shared lc3 loader constants: memory size, release delay, FSM state encoding and output flags.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int MEMORY_WORDCOUNT       = 512;
    localparam int MEM_WORDS_DEFAULT      = MEMORY_WORDCOUNT;
    localparam int RELEASE_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_ORIGIN  = 3'd0,
        S_DATA    = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK   = 3'd2,
`endif
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_ERROR   = 3'd5
    } state_e;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic err;
        logic cpu_rst_n;
    } flags_t;

    // Registered status outputs that belong to each state.
    function automatic flags_t flags_of(state_e s);
        flags_t f;
        // NOTE: f is defaulted before the case so every path assigns every field.
        f = '0;
        case (s)
            S_ORIGIN, S_DATA: begin
                f.ready = 1'b1;
                f.busy  = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                f.ready = 1'b1;
                f.busy  = 1'b1;
            end
`endif
            S_RELEASE: f.busy = 1'b1;
            S_RUN: begin
                f.done      = 1'b1;
                f.cpu_rst_n = 1'b1;
            end
            S_ERROR: f.err = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader stream input (valid/ready) and memory write port bundled into one interface.
interface prog_loader_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/loader_release_timer.sv
// Countdown for the core-release delay: load sets CYCLES, each tick decrements,
// expired flags the tick that ends the count. CYCLES must be at least 1.
module loader_release_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic tick,
    output logic expired
);
    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(CYCLES);
        end else if (tick && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = tick && (count == CW'(1));
endmodule

// File: rtl/prog_loader.sv
// Program loader: streams an origin word then data words into lc3 memory and releases the core.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum word verified before release.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM_WORDS      = MEM_WORDS_DEFAULT,
    parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    prog_loader_if.slave bus,
    input  logic         start,
    output logic         cpu_reset_n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  word_count
);
    state_e      state;
    flags_t      flags;
    logic [15:0] ptr;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        rel_load;
    logic        rel_tick;
    logic        rel_expired;
    logic        accept;
    logic        addr_ok;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;
`endif

    assign accept  = bus.in_valid && flags.ready;
    assign addr_ok = 32'(ptr) < MEM_WORDS;

    assign bus.in_ready  = flags.ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = flags.busy;
    assign done          = flags.done;
    assign err           = flags.err;
    assign cpu_reset_n   = flags.cpu_rst_n;

    // Timer is loaded one cycle after the final accepted word, so the hold-low window
    // starts in the cycle after the last mem_we.
    assign rel_tick = (state == S_RELEASE) && !rel_load;

    loader_release_timer #(.CYCLES(RELEASE_CYCLES)) u_release_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rel_load),
        .tick    (rel_tick),
        .expired (rel_expired)
    );

    // NOTE: all state here is registered with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_ORIGIN;
            flags      <= '0;
            ptr        <= '0;
            word_count <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rel_load   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            we_q     <= 1'b0;
            rel_load <= 1'b0;
            flags    <= flags_of(state);
            case (state)
                S_ORIGIN: if (accept) begin
                    ptr <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    sum <= '0;
`endif
                    if (bus.in_last) begin
                        state    <= S_RELEASE;
                        flags    <= flags_of(S_RELEASE);
                        rel_load <= 1'b1;
                    end else begin
                        state <= S_DATA;
                        flags <= flags_of(S_DATA);
                    end
                end
                S_DATA: if (accept) begin
                    if (!addr_ok) begin
                        state <= S_ERROR;
                        flags <= flags_of(S_ERROR);
                    end else begin
                        we_q       <= 1'b1;
                        addr_q     <= ptr;
                        wdata_q    <= bus.in_data;
                        ptr        <= ptr + 16'd1;
                        word_count <= word_count + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= sum + bus.in_data;
                        if (bus.in_last) begin
                            state <= S_CHECK;
                            flags <= flags_of(S_CHECK);
                        end
`else
                        if (bus.in_last) begin
                            state    <= S_RELEASE;
                            flags    <= flags_of(S_RELEASE);
                            rel_load <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: if (accept) begin
                    if (16'(sum + bus.in_data) == 16'd0) begin
                        state    <= S_RELEASE;
                        flags    <= flags_of(S_RELEASE);
                        rel_load <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        flags <= flags_of(S_ERROR);
                    end
                end
`endif
                S_RELEASE: if (rel_expired) begin
                    state <= S_RUN;
                    flags <= flags_of(S_RUN);
                end
                S_RUN, S_ERROR: if (start) begin
                    state      <= S_ORIGIN;
                    flags      <= flags_of(S_ORIGIN);
                    word_count <= '0;
                end
                default: begin
                    state <= S_ORIGIN;
                    flags <= flags_of(S_ORIGIN);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: driver pushes expected writes, monitor pops on mem_we.
module tb_prog_loader;
    localparam int MEM_WORDS = 512;
    localparam int RC        = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_reset_n, busy, done, err;
    logic [15:0] word_count;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];

    prog_loader_if bus();

    prog_loader #(.MEM_WORDS(MEM_WORDS), .RELEASE_CYCLES(RC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .start       (start),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every mem_we must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (cycle %0d)",
                         bus.mem_addr, bus.mem_wdata, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", bus.mem_addr, e.addr);
                check("write_data", bus.mem_wdata, e.data);
                check("write_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_cpu_reset_n"}, cpu_reset_n, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [15:0] d, input logic last, input bit exp_wr,
                             input logic [15:0] exp_addr, output int acc_n, output bit ok);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        acc_n = cyc;
        if (bus.in_ready !== 1'b1) begin
            check("in_ready_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        if (exp_wr) exp_q.push_back('{addr: exp_addr, data: d, cyc: acc_n + 1});
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        ok = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_cpu_reset_n", cpu_reset_n, 0);
        check("restart_word_count", word_count, 0);
        check("restart_busy", busy, 1);
        check("restart_in_ready", bus.in_ready, 1);
        check("restart_done", done, 0);
        check("restart_err", err, 0);
    endtask

    // Reference model: data word i targets origin+i; the first out-of-range target aborts.
    task automatic run_load(input logic [15:0] origin, input logic [15:0] data[$],
                            input int gap_mode, input bit noise);
        int n, k_err, acc_n, rise;
        bit ok;
`ifdef LOADER_CHECKSUM_EN
        logic [15:0] sum;
        sum = '0;
`endif
        n = data.size();
        k_err = -1;
        for (int i = 0; i < n; i++)
            if (k_err < 0 && int'(origin) + i >= MEM_WORDS) k_err = i;
        push_word(origin, n == 0, 1'b0, 16'h0, acc_n, ok);
        if (!ok) return;
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                start = noise;
                @(negedge clk);
                start = 1'b0;
            end
            push_word(data[i], i == n - 1, (k_err < 0 || i < k_err), origin + 16'(i), acc_n, ok);
            if (!ok) return;
`ifdef LOADER_CHECKSUM_EN
            sum = sum + data[i];
`endif
            if (i == k_err) break;
        end
        if (k_err >= 0) begin
            @(negedge clk);
            check("err_flag", err, 1);
            check("err_done", done, 0);
            check("err_cpu_reset_n", cpu_reset_n, 0);
            check("err_in_ready", bus.in_ready, 0);
            check("err_word_count", word_count, k_err);
            check("err_writes_outstanding", exp_q.size(), 0);
            return;
        end
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) begin
            push_word(16'h0 - sum, 1'b1, 1'b0, 16'h0, acc_n, ok);
            if (!ok) return;
        end
`endif
        rise = -1;
        for (int i = 0; i < 60; i++) begin
            if (cpu_reset_n === 1'b1 || err === 1'b1) begin
                rise = cyc;
                break;
            end
            start = noise && (i == 1) && (busy === 1'b1);
            @(negedge clk);
        end
        start = 1'b0;
        check("release_cycle", rise, acc_n + 2 + RC);
        check("run_done", done, 1);
        check("run_err", err, 0);
        check("run_busy", busy, 0);
        check("run_in_ready", bus.in_ready, 0);
        check("run_word_count", word_count, n);
        check("run_writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        logic [15:0] origin;
        int acc_n;
        bit ok;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;

        q = {16'h1234, 16'h5678};
        run_load(16'h0000, q, 0, 1'b0);

        pulse_start();
        q = {};
        run_load(16'h0010, q, 0, 1'b0);

        pulse_start();
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(16'($urandom));
        run_load(16'h0100, q, 1, 1'b0);

        pulse_start();
        q = {16'hAAAA, 16'hBBBB};
        run_load(16'h01FF, q, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            pulse_start();
            origin = (t % 2 == 0) ? 16'($urandom_range(0, 500)) : 16'($urandom_range(490, 515));
            q = {};
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) q.push_back(16'($urandom));
            run_load(origin, q, 2, 1'b1);
        end

        // Reset in the cycle after the third data word: its write shows, nothing after.
        pulse_start();
        push_word(16'h0040, 1'b0, 1'b0, 16'h0, acc_n, ok);
        for (int i = 0; i < 3; i++)
            push_word(16'h7000 + 16'(i), 1'b0, 1'b1, 16'h0040 + 16'(i), acc_n, ok);
        reset_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        @(negedge clk);
        check_reset("mid_reset");
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(16'($urandom));
        run_load(16'h0080, q, 2, 1'b1);

        repeat (3) @(negedge clk);
        check("final_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
